// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader_if
// Brief    : Valid/ready word stream carrying a last-word tag.
// Revision : 1.0
// ============================================================================
interface bram_stream_reader_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader
// Brief    : Sequential BRAM read sequencer; absorbs read latency through a
//            credit-checked FIFO and presents words as a valid/ready stream.
// Revision : 1.0
// ============================================================================
module bram_stream_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire                    start,
  input  wire  [ADDR_W-1:0]      base_addr,
  input  wire  [ADDR_W:0]        len,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  wire  [DATA_W-1:0]      mem_dout,
  bram_stream_reader_if.master   m
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [ADDR_W:0]   c_max_len  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_rem_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_rem_zero = '0;
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
  localparam logic [OCC_W-1:0]  c_occ_one  = OCC_W'(1);
  localparam logic [OCC_W-1:0]  c_occ_zero = '0;
  localparam logic [OCC_W:0]    c_depth    = (OCC_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [ADDR_W:0]     r_rem;
  logic [OCC_W-1:0]    r_inflight;
  logic [OCC_W-1:0]    r_occ;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic                r_fifo_last [FIFO_DEPTH];
  logic                r_done;
  logic [RD_LAT-1:0]   r_tok_v;
  logic [RD_LAT-1:0]   r_tok_l;

  logic [ADDR_W:0]     w_len_clamped;
  logic                w_credit_ok;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_push;
  logic                w_push_last;
  logic                w_pop;

  assign w_len_clamped = (len > c_max_len) ? c_max_len : len;

  // Credits use registered counts only; a pop this cycle frees its credit next cycle.
  assign w_credit_ok  = ({1'b0, r_occ} + {1'b0, r_inflight}) < c_depth;
  assign w_issue      = (r_state == S_READ) && (r_rem != c_rem_zero) && w_credit_ok;
  assign w_issue_last = w_issue && (r_rem == c_rem_one);
  assign w_push       = r_tok_v[RD_LAT-1];
  assign w_push_last  = r_tok_l[RD_LAT-1];
  assign w_pop        = m.valid && m.ready;

  assign mem_en   = w_issue;
  assign mem_addr = w_issue ? r_addr : r_last_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

  assign m.valid = (r_occ != c_occ_zero);
  assign m.data  = r_fifo_data[r_rd_ptr];
  assign m.last  = r_fifo_last[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_clamped != c_rem_zero) w_state_nxt = S_READ;
          else                             w_done_nxt  = 1'b1;
        end
      end
      S_READ: begin
        if (w_issue_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && m.last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_rem       <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_addr <= base_addr;
      r_rem  <= w_len_clamped;
    end else if (w_issue) begin
      r_addr      <= r_addr + c_addr_one;
      r_last_addr <= r_addr;
      r_rem       <= r_rem - c_rem_one;
    end
  end

  // In-flight token pipeline mirrors the BRAM read latency.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tok_v <= '0;
          r_tok_l <= '0;
        end else begin
          r_tok_v <= w_issue;
          r_tok_l <= w_issue_last;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tok_v <= '0;
          r_tok_l <= '0;
        end else begin
          r_tok_v <= {r_tok_v[RD_LAT-2:0], w_issue};
          r_tok_l <= {r_tok_l[RD_LAT-2:0], w_issue_last};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_issue && !w_push) begin
      r_inflight <= r_inflight + c_occ_one;
    end else if (!w_issue && w_push) begin
      r_inflight <= r_inflight - c_occ_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_dout;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + c_occ_one;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - c_occ_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_reader
// Brief    : Randomized bench for bram_stream_reader with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_bram_stream_reader;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  bram_stream_reader_if #(.DATA_W(DATA_W)) s_if ();

  bram_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .m(s_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: address register then output register (two-cycle read)
  logic [DATA_W-1:0] bram [DEPTH];
  logic [ADDR_W-1:0] bram_a1;
  logic [DATA_W-1:0] bram_d2;
  always @(posedge clk) begin
    if (mem_en) bram_a1 <= mem_addr;
    bram_d2 <= bram[bram_a1];
  end
  assign mem_dout = bram_d2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_d_q [$];
  bit                exp_l_q [$];
  logic [ADDR_W-1:0] exp_a_q [$];
  int cyc, n_issued, n_popped, n_done, first_valid, done_cyc;
  bit prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;

  function automatic bit pick_rdy(input int rmode, input int c, input int sa, input int sl);
    if (c >= sa && c < sa + sl) return 1'b0;
    case (rmode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      2:       return ($urandom % 4) != 0;
      default: return ($urandom % 2) != 0;
    endcase
  endfunction

  task automatic load_model(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    int eff;
    eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
    exp_d_q.delete(); exp_l_q.delete(); exp_a_q.delete();
    for (int i = 0; i < eff; i++) begin
      exp_a_q.push_back(ADDR_W'((int'(b) + i) % DEPTH));
      exp_d_q.push_back(bram[(int'(b) + i) % DEPTH]);
      exp_l_q.push_back(i == eff - 1);
    end
    n_issued = 0; n_popped = 0; n_done = 0;
    first_valid = -1; done_cyc = -1; cyc = 0; prev_stall = 1'b0;
  endtask

  // One clock: drive inputs, then observe the stream, read issue and done.
  task automatic cycle(input bit r, input bit st, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W:0] l, input bit rdy);
    logic [DATA_W-1:0] ed;
    bit el;
    logic [ADDR_W-1:0] ea;
    @(posedge clk); #1;
    rst = r; start = st; base_addr = b; len = l; s_if.ready = rdy;
    #1;
    if (prev_stall) begin
      n_checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== prev_data || s_if.last !== prev_last) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                 s_if.valid, s_if.data, s_if.last, prev_data, prev_last);
      end
    end
    if (mem_en === 1'b1) begin
      n_issued++;
      n_checks++;
      if (exp_a_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_read: got addr %0d, expected no read", mem_addr);
      end else begin
        ea = exp_a_q.pop_front();
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL read_addr: got %0d, expected %0d", mem_addr, ea);
        end
      end
      n_checks++;
      if (n_issued - n_popped > FIFO_DEPTH) begin
        n_fail++;
        $display("FAIL outstanding: got %0d, expected <= %0d", n_issued - n_popped, FIFO_DEPTH);
      end
    end
    if (s_if.valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (s_if.valid === 1'b1 && rdy) begin
      n_popped++;
      n_checks++;
      if (exp_d_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_word: got %h, expected none", s_if.data);
      end else begin
        ed = exp_d_q.pop_front();
        el = exp_l_q.pop_front();
        if (s_if.data !== ed || s_if.last !== el) begin
          n_fail++;
          $display("FAIL word: got %h last %b, expected %h last %b", s_if.data, s_if.last, ed, el);
        end
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_at_done: got %b, expected 0", busy);
      end
    end
    prev_stall = !r && (s_if.valid === 1'b1) && !rdy;
    prev_data  = s_if.data;
    prev_last  = s_if.last;
    cyc++;
  endtask

  task automatic run_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                         input int rmode, input int stall_at, input int stall_len,
                         input int restart_at, output int fv, output int dc);
    bit rdy;
    load_model(b, l);
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      rdy = pick_rdy(rmode, c, stall_at, stall_len);
      if (c == 0)               cycle(1'b0, 1'b1, b, l, rdy);
      else if (c == restart_at) cycle(1'b0, 1'b1, b + 6'd7, 7'd3, rdy);
      else                      cycle(1'b0, 1'b0, '0, '0, rdy);
    end
    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if (done_cyc < 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d pulses, expected 1", n_done);
    end
    n_checks++;
    if (exp_d_q.size() != 0 || exp_a_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing: got %0d words/%0d reads left, expected 0/0",
               exp_d_q.size(), exp_a_q.size());
    end
    fv = first_valid;
    dc = done_cyc;
  endtask

  task automatic test_reset();
    load_model('0, '0);
    repeat (3) cycle(1'b1, 1'b0, '0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({busy, done, mem_en, s_if.valid, s_if.last} !== 5'b0 || mem_addr !== '0 || s_if.data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got b%b d%b e%b a%0d v%b l%b data%h, expected all 0",
               busy, done, mem_en, mem_addr, s_if.valid, s_if.last, s_if.data);
    end
  endtask

  task automatic test_basic();
    int fv, dc;
    bram[2] = 16'h3F80; bram[3] = 16'h4208;
    run_cmd(6'd2, 7'd2, 0, 999, 0, -1, fv, dc);
    n_checks++;
    if (fv != RD_LAT + 2) begin
      n_fail++; $display("FAIL basic_first_valid: got cycle %0d, expected %0d", fv, RD_LAT + 2);
    end
    n_checks++;
    if (dc != 2 + RD_LAT + 2) begin
      n_fail++; $display("FAIL basic_done: got cycle %0d, expected %0d", dc, 2 + RD_LAT + 2);
    end
  endtask

  task automatic test_wrap();
    int fv, dc;
    for (int k = 0; k < DEPTH; k++) bram[k] = 16'h3F80 + 16'(k);
    run_cmd(6'd62, 7'd4, 0, 999, 0, -1, fv, dc);
    n_checks++;
    if (dc != 4 + RD_LAT + 2) begin
      n_fail++; $display("FAIL wrap_done: got cycle %0d, expected %0d", dc, 4 + RD_LAT + 2);
    end
  endtask

  task automatic test_backpressure();
    int fv, dc;
    run_cmd(6'd0, 7'd64, 1, 30, 20, -1, fv, dc);
  endtask

  task automatic test_len_zero();
    int fv, dc;
    run_cmd(6'd9, 7'd0, 0, 999, 0, -1, fv, dc);
    n_checks++;
    if (dc != 1 || fv != -1) begin
      n_fail++; $display("FAIL len_zero: got done %0d valid %0d, expected done 1 valid -1", dc, fv);
    end
  endtask

  task automatic test_reset_mid();
    int fv, dc, guard;
    for (int k = 0; k < DEPTH; k++) bram[k] = 16'($urandom);
    load_model(6'd20, 7'd10);
    cycle(1'b0, 1'b1, 6'd20, 7'd10, 1'b1);
    guard = 0;
    while (n_popped < 3 && guard < 50) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1);
      guard++;
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
    exp_d_q.delete(); exp_l_q.delete(); exp_a_q.delete();
    n_done = 0;
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({busy, done, mem_en, s_if.valid, s_if.last} !== 5'b0 || mem_addr !== '0 || s_if.data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got b%b d%b e%b a%0d v%b l%b data%h, expected all 0",
               busy, done, mem_en, mem_addr, s_if.valid, s_if.last, s_if.data);
    end
    repeat (8) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL reset_mid_done: got %0d pulses, expected 0", n_done);
    end
    run_cmd(6'd5, 7'd1, 0, 999, 0, -1, fv, dc);
  endtask

  task automatic test_restart();
    int fv, dc;
    run_cmd(6'd10, 7'd6, 0, 999, 0, 3, fv, dc);
    n_checks++;
    if (dc != 6 + RD_LAT + 2) begin
      n_fail++; $display("FAIL restart_done: got cycle %0d, expected %0d", dc, 6 + RD_LAT + 2);
    end
  endtask

  task automatic test_random();
    int fv, dc, rmode, eff;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0] l;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < DEPTH; k++) bram[k] = 16'($urandom);
      b = ADDR_W'($urandom);
      l = (ADDR_W+1)'($urandom_range(0, 127));
      rmode = (n % 3 == 0) ? 0 : 1 + int'($urandom_range(1, 2));
      eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
      run_cmd(b, l, rmode, 999, 0, -1, fv, dc);
      if (rmode == 0) begin
        n_checks++;
        if (dc != ((eff == 0) ? 1 : eff + RD_LAT + 2)) begin
          n_fail++;
          $display("FAIL random_done: len %0d got cycle %0d, expected %0d",
                   eff, dc, (eff == 0) ? 1 : eff + RD_LAT + 2);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; s_if.ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) bram[k] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
